// File: rtl/exe_stage_pkg.sv
// Execute stage shared types: bus widths, ALU op encoding,
// divider states and the ALU itself.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 169;
  localparam int ES_TO_MS_BUS_WD = 80;
  localparam int ES_FWD_WD       = 39;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        lb, lbu, lh, lhu, lwl, lwr;
    logic        sb, sh, sw, swl, swr;
    logic        mult, multu, div, divu;
    logic        mfhi, mflo, mthi, mtlo;
    logic        res_from_mem;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_t;

  // Shifts take the amount from a and shift b.
  function automatic logic [31:0] alu(
    input logic [11:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = '0;
    unique case (1'b1)
      op[0]:   r = a + b;
      op[1]:   r = a - b;
      op[2]:   r = {31'd0, $signed(a) < $signed(b)};
      op[3]:   r = {31'd0, a < b};
      op[4]:   r = a & b;
      op[5]:   r = ~(a | b);
      op[6]:   r = a | b;
      op[7]:   r = a ^ b;
      op[8]:   r = b << a[4:0];
      op[9]:   r = b >> a[4:0];
      op[10]:  r = $signed(b) >>> a[4:0];
      op[11]:  r = {b[15:0], 16'd0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX/MEM handshake and data-SRAM request signals.
// slave is the execute stage; master is its environment.
interface exe_stage_if;
  logic                                      ms_allowin;
  logic                                      es_allowin;
  logic                                      ds_to_es_valid;
  logic [exe_stage_pkg::DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                                      es_to_ms_valid;
  logic [exe_stage_pkg::ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [exe_stage_pkg::ES_FWD_WD-1:0]       es_forward_bus;
  logic                                      data_sram_en;
  logic [3:0]                                data_sram_wen;
  logic [31:0]                               data_sram_addr;
  logic [31:0]                               data_sram_wdata;

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus,
    output es_forward_bus, data_sram_en, data_sram_wen,
    output data_sram_addr, data_sram_wdata
  );

  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus,
    input  es_forward_bus, data_sram_en, data_sram_wen,
    input  data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider, 32 steps on magnitudes,
// signs re-applied on the way out.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [32:0] shifted, diff;

  // State and datapath registers; reset may land mid-divide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Next state: 32 BUSY cycles, DONE held until acked
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (ack) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Operand latch on start, one restoring step per BUSY cycle
  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (state_q == DIV_IDLE && start) begin
      quo_d  = (sgn && a[31]) ? -a : a;
      dvs_d  = (sgn && b[31]) ? -b : b;
      rem_d  = '0;
      cnt_d  = '0;
      negq_d = sgn && (a[31] ^ b[31]);
      negr_d = sgn && a[31];
    end else if (state_q == DIV_BUSY) begin
      cnt_d = cnt_q + 5'd1;
      quo_d = {quo_q[30:0], ~diff[32]};
      rem_d = diff[32] ? shifted[31:0] : diff[31:0];
    end
  end

  // Status flags and signed fix-up of the magnitudes
  always_comb begin
    busy      = (state_q == DIV_BUSY);
    done      = (state_q == DIV_DONE);
    quotient  = negq_q ? -quo_q : quo_q;
    remainder = negr_q ? -rem_q : rem_q;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, ALU, mult/div, HI/LO,
// data-SRAM request and forwarding to ID.
module exe_stage
  import exe_stage_pkg::*;
(
  input logic        clk,
  input logic        reset,
  exe_stage_if.slave io
);

  logic        es_valid_q, es_valid_d;
  ds_to_es_t   bus_q, bus_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div, is_load, is_store;
  logic        es_ready_go, es_allowin, fire;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] alu_res, es_result;
  logic [63:0] ma, mb, prod;
  logic [1:0]  a_lo;
  logic [3:0]  wen;
  logic [31:0] wdata;

  div_iter u_div (
    .clk       (clk),
    .rst       (reset),
    .start     (div_start),
    .sgn       (bus_q.div),
    .a         (bus_q.src1),
    .b         (bus_q.src2),
    .ack       (fire),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Pipeline register and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      bus_q      <= bus_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Handshake; divides hold the stage until the divider is DONE
  always_comb begin
    is_div      = bus_q.div | bus_q.divu;
    is_load     = bus_q.res_from_mem | bus_q.lb | bus_q.lbu
                | bus_q.lh | bus_q.lhu | bus_q.lwl | bus_q.lwr;
    is_store    = bus_q.sb | bus_q.sh | bus_q.sw
                | bus_q.swl | bus_q.swr;
    es_ready_go = !is_div || div_done;
    es_allowin  = !es_valid_q || (es_ready_go && io.ms_allowin);
    fire        = es_valid_q && es_ready_go && io.ms_allowin;
    div_start   = es_valid_q && is_div && !div_busy && !div_done;
    es_valid_d  = es_allowin ? io.ds_to_es_valid : es_valid_q;
    bus_d       = bus_q;
    if (io.ds_to_es_valid && es_allowin) bus_d = io.ds_to_es_bus;
  end

  // Result select and HI/LO writes, committed only on fire
  always_comb begin
    alu_res   = alu(bus_q.alu_op, bus_q.src1, bus_q.src2);
    ma        = {{32{bus_q.mult & bus_q.src1[31]}}, bus_q.src1};
    mb        = {{32{bus_q.mult & bus_q.src2[31]}}, bus_q.src2};
    prod      = ma * mb;
    es_result = alu_res;
    if (bus_q.mfhi)      es_result = hi_q;
    else if (bus_q.mflo) es_result = lo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (fire) begin
      if (bus_q.mult || bus_q.multu) {hi_d, lo_d} = prod;
      if (bus_q.mthi) hi_d = bus_q.src1;
      if (bus_q.mtlo) lo_d = bus_q.src1;
      if (is_div && bus_q.src2 != 32'd0) begin
        hi_d = div_rem;
        lo_d = div_quo;
      end
    end
  end

  // Store byte lanes from the low address bits
  always_comb begin
    a_lo  = alu_res[1:0];
    wen   = 4'b0000;
    wdata = bus_q.rt_value;
    unique case (1'b1)
      bus_q.sb: begin
        wen   = 4'b0001 << a_lo;
        wdata = {4{bus_q.rt_value[7:0]}};
      end
      bus_q.sh: begin
        wen   = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus_q.rt_value[15:0]}};
      end
      bus_q.sw: wen = 4'b1111;
      bus_q.swl: begin
        wen   = 4'b1111 >> (~a_lo);
        wdata = bus_q.rt_value >> {~a_lo, 3'b000};
      end
      bus_q.swr: begin
        wen   = 4'b1111 << a_lo;
        wdata = bus_q.rt_value << {a_lo, 3'b000};
      end
      default: wen = 4'b0000;
    endcase
  end

  // Outputs to ID, MEM and the data SRAM
  always_comb begin
    io.es_allowin      = es_allowin;
    io.es_to_ms_valid  = es_valid_q && es_ready_go;
    io.es_to_ms_bus    = {bus_q.lb, bus_q.lbu, bus_q.lh, bus_q.lhu,
                          bus_q.lwl, bus_q.lwr, bus_q.res_from_mem,
                          bus_q.gr_we, bus_q.dest, es_result, bus_q.pc};
    io.es_forward_bus  = {es_valid_q && (bus_q.gr_we != 4'd0),
                          bus_q.res_from_mem, bus_q.dest, es_result};
    io.data_sram_en    = es_valid_q && (is_load || is_store)
                         && io.ms_allowin;
    io.data_sram_wen   = (es_valid_q && is_store && io.ms_allowin)
                         ? wen : 4'b0000;
    io.data_sram_addr  = alu_res;
    io.data_sram_wdata = wdata;
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with an in-order scoreboard
// checked whenever an instruction leaves for MEM.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;

  exe_stage_if ifc ();

  exe_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bus;
    logic [38:0] fwd;
    logic        mem;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic        chk_wd;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pcv = 32'hbfc0_0000;
  ds_to_es_t   b;
  int          n;
  logic        v, al, as;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic ds_to_es_t mk(input logic [11:0] op,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [31:0] rt);
    ds_to_es_t r;
    r          = '0;
    r.alu_op   = op;
    r.src1     = s1;
    r.src2     = s2;
    r.rt_value = rt;
    r.gr_we    = 4'hf;
    r.dest     = 5'd8;
    return r;
  endfunction

  // One cycle: sample at posedge+2, pop on fire, end at posedge+1
  task automatic cyc(output logic vo, output logic alo);
    exp_t e;
    #1;
    vo  = ifc.es_to_ms_valid;
    alo = ifc.es_allowin;
    if (ifc.es_to_ms_valid && ifc.ms_allowin) begin
      chk("sb_nonempty", 80'(sbq.size() != 0), 80'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ms_bus", ifc.es_to_ms_bus, e.bus);
        chk("fwd", 80'(ifc.es_forward_bus), 80'(e.fwd));
        chk("sram_en", 80'(ifc.data_sram_en), 80'(e.mem));
        chk("sram_wen", 80'(ifc.data_sram_wen), 80'(e.wen));
        if (e.mem)
          chk("sram_addr", 80'(ifc.data_sram_addr), 80'(e.bus[63:32]));
        if (e.chk_wd)
          chk("sram_wdata", 80'(ifc.data_sram_wdata), 80'(e.wd));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ds_to_es_t bi, input logic [31:0] res,
    input logic mem, input logic [3:0] wen, input logic [31:0] wd,
    input logic chk_wd);
    exp_t e;
    logic vo, alo;
    int   k;
    k = 0;
    while (!ifc.es_allowin && k < 100) begin
      cyc(vo, alo);
      k++;
    end
    chk("allowin_wait", 80'(ifc.es_allowin), 80'd1);
    bi.pc = pcv;
    pcv   = pcv + 32'd4;
    e.bus = {bi.lb, bi.lbu, bi.lh, bi.lhu, bi.lwl, bi.lwr,
             bi.res_from_mem, bi.gr_we, bi.dest, res, bi.pc};
    e.fwd = {bi.gr_we != 4'd0, bi.res_from_mem, bi.dest, res};
    e.mem = mem;
    e.wen = wen;
    e.wd  = wd;
    e.chk_wd = chk_wd;
    sbq.push_back(e);
    ifc.ds_to_es_bus   = bi;
    ifc.ds_to_es_valid = 1'b1;
    cyc(vo, alo);
    ifc.ds_to_es_valid = 1'b0;
  endtask

  task automatic op(input ds_to_es_t bi, input logic [31:0] res);
    issue(bi, res, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic rd_hilo(input logic [31:0] hi, input logic [31:0] lo);
    ds_to_es_t r;
    r = mk(OP_ADD, 0, 0, 0); r.mfhi = 1'b1; op(r, hi);
    r = mk(OP_ADD, 0, 0, 0); r.mflo = 1'b1; op(r, lo);
  endtask

  // Cycles spent in EX before es_to_ms_valid rises
  task automatic wait_out(output int k, output logic al_seen);
    logic vo, alo;
    k = 0;
    al_seen = 1'b0;
    do begin
      cyc(vo, alo);
      if (!vo) begin
        k++;
        al_seen = al_seen | alo;
      end
    end while (!vo && k < 200);
  endtask

  task automatic st(input logic [31:0] s2, input logic [31:0] rt,
    input int kind, input logic [3:0] wen, input logic [31:0] wd);
    ds_to_es_t r;
    r = mk(OP_ADD, 32'h0000_1000, s2, rt);
    r.gr_we = 4'd0;
    r.sb  = (kind == 0);
    r.sh  = (kind == 1);
    r.sw  = (kind == 2);
    r.swl = (kind == 3);
    r.swr = (kind == 4);
    issue(r, 32'h0000_1000 + s2, 1'b1, wen, wd, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    ifc.ms_allowin     = 1'b1;
    ifc.ds_to_es_valid = 1'b0;
    ifc.ds_to_es_bus   = '0;
    #7;
    chk("rst_allowin", 80'(ifc.es_allowin), 80'd1);
    chk("rst_to_ms_valid", 80'(ifc.es_to_ms_valid), 80'd0);
    chk("rst_sram_en", 80'(ifc.data_sram_en), 80'd0);
    chk("rst_sram_wen", 80'(ifc.data_sram_wen), 80'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    rd_hilo(32'h0, 32'h0);

    op(mk(OP_ADD, 5, 7, 0), 32'd12);
    op(mk(OP_SUB, 5, 7, 0), 32'hffff_fffe);
    op(mk(OP_SLT, 32'hffff_ffff, 1, 0), 32'd1);
    op(mk(OP_SLTU, 32'hffff_ffff, 1, 0), 32'd0);
    op(mk(OP_NOR, 0, 0, 0), 32'hffff_ffff);
    op(mk(OP_XOR, 32'hf0f0, 32'hff00, 0), 32'h0ff0);
    op(mk(OP_SLL, 4, 1, 0), 32'd16);
    op(mk(OP_SRA, 4, 32'h8000_0000, 0), 32'hf800_0000);
    op(mk(OP_LUI, 0, 32'h1234, 0), 32'h1234_0000);

    b = mk(OP_ADD, 32'hffff_ffff, 2, 0); b.mult = 1'b1;
    op(b, 32'd1);
    rd_hilo(32'hffff_ffff, 32'hffff_fffe);
    b = mk(OP_ADD, 32'hffff_ffff, 2, 0); b.multu = 1'b1;
    op(b, 32'd1);
    rd_hilo(32'h1, 32'hffff_fffe);

    b = mk(OP_ADD, 32'hdead_beef, 0, 0); b.mthi = 1'b1;
    op(b, 32'hdead_beef);
    b = mk(OP_ADD, 32'h0bad_f00d, 0, 0); b.mtlo = 1'b1;
    op(b, 32'h0bad_f00d);
    rd_hilo(32'hdead_beef, 32'h0bad_f00d);

    b = mk(OP_ADD, 100, 7, 0); b.divu = 1'b1; b.gr_we = 4'd0;
    op(b, 32'd107);
    wait_out(n, as);
    chk("divu_latency", 80'(n), 80'd33);
    chk("divu_allowin_low", 80'(as), 80'd0);
    rd_hilo(32'd2, 32'd14);

    b = mk(OP_ADD, 32'hffff_fff9, 2, 0); b.div = 1'b1; b.gr_we = 4'd0;
    op(b, 32'hffff_fffb);
    ifc.ms_allowin = 1'b0;
    wait_out(n, as);
    chk("div_hold_latency", 80'(n), 80'd33);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", 80'(ifc.es_to_ms_valid), 80'd1);
      chk("hold_allowin", 80'(ifc.es_allowin), 80'd0);
      chk("hold_sram_en", 80'(ifc.data_sram_en), 80'd0);
      @(posedge clk);
      #1;
    end
    ifc.ms_allowin = 1'b1;
    cyc(v, al);
    rd_hilo(32'hffff_ffff, 32'hffff_fffd);

    b = mk(OP_ADD, 5, 0, 0); b.div = 1'b1; b.gr_we = 4'd0;
    op(b, 32'd5);
    wait_out(n, as);
    chk("div0_latency", 80'(n), 80'd33);
    rd_hilo(32'hffff_ffff, 32'hffff_fffd);

    st(2, 32'h1234_5678, 0, 4'b0100, 32'h7878_7878);
    st(2, 32'h1234_5678, 1, 4'b1100, 32'h5678_5678);
    st(4, 32'h1234_5678, 2, 4'b1111, 32'h1234_5678);
    st(1, 32'haabb_ccdd, 3, 4'b0011, 32'h0000_aabb);
    st(3, 32'haabb_ccdd, 3, 4'b1111, 32'haabb_ccdd);
    st(2, 32'haabb_ccdd, 4, 4'b1100, 32'hccdd_0000);
    st(0, 32'haabb_ccdd, 4, 4'b1111, 32'haabb_ccdd);
    b = mk(OP_ADD, 32'h0000_1000, 8, 0); b.res_from_mem = 1'b1;
    issue(b, 32'h0000_1008, 1'b1, 4'd0, 32'd0, 1'b0);

    b = mk(OP_ADD, 32'h0000_1000, 12, 32'h55); b.sw = 1'b1;
    b.gr_we = 4'd0;
    issue(b, 32'h0000_100c, 1'b1, 4'b1111, 32'h55, 1'b1);
    ifc.ms_allowin = 1'b0;
    #1;
    chk("stall_valid", 80'(ifc.es_to_ms_valid), 80'd1);
    chk("stall_sram_en", 80'(ifc.data_sram_en), 80'd0);
    chk("stall_sram_wen", 80'(ifc.data_sram_wen), 80'd0);
    @(posedge clk);
    #1;
    ifc.ms_allowin = 1'b1;
    cyc(v, al);

    b = mk(OP_ADD, 100, 7, 0); b.divu = 1'b1; b.gr_we = 4'd0;
    op(b, 32'd107);
    for (int i = 0; i < 11; i++) cyc(v, al);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 80'(ifc.es_to_ms_valid), 80'd0);
    chk("midrst_allowin", 80'(ifc.es_allowin), 80'd1);
    chk("midrst_sram_en", 80'(ifc.data_sram_en), 80'd0);
    chk("midrst_sram_wen", 80'(ifc.data_sram_wen), 80'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_hilo(32'h0, 32'h0);
    b = mk(OP_ADD, 100, 7, 0); b.divu = 1'b1; b.gr_we = 4'd0;
    op(b, 32'd107);
    wait_out(n, as);
    chk("postrst_latency", 80'(n), 80'd33);
    rd_hilo(32'd2, 32'd14);

    for (int i = 0; i < 4; i++) cyc(v, al);
    chk("sb_drained", 80'(sbq.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage MIPS pipeline, between ID and MEM. Holds one instruction in a pipeline register and computes its ALU result. Runs multiply immediately and divide in an iterative 32-step unit that stalls the stage, and owns the HI/LO registers. Issues data-SRAM requests with store byte enables and shifted store data. Passes the load-decode bus to MEM and forwards its result to ID.

## Interface
Parameters:
- none; bus widths `DS_TO_ES_BUS_WD`, `ES_TO_MS_BUS_WD` (=80) and `ES_FWD_WD` (=39) come from mycpu.h.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- ms_allowin  in  1  MEM can accept.
- es_allowin  out  1  = !es_valid || es_ready_go && ms_allowin.
- ds_to_es_valid  in  1  ID has an instruction.
- ds_to_es_bus  in  `DS_TO_ES_BUS_WD`  fields, in order:
  - alu_op[11:0]
  - lb, lbu, lh, lhu, lwl, lwr
  - sb, sh, sw, swl, swr
  - mult, multu, div, divu, mfhi, mflo, mthi, mtlo
  - res_from_mem, gr_we[3:0], dest[4:0], src1, src2, rt_value, pc
- es_to_ms_valid  out  1  = es_valid && es_ready_go.
- es_to_ms_bus  out  80  {lb, lbu, lh, lhu, lwl, lwr, res_from_mem, gr_we[3:0], dest, es_result, pc}; bit 79 = lb.
- es_forward_bus  out  39  fields:
  - [38] es_valid && gr_we!=0
  - [37] res_from_mem (consumer stalls)
  - [36:32] dest
  - [31:0] es_result
- data_sram_en  out  1  request strobe.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  = ALU result.
- data_sram_wdata  out  32  store data.

## Operation
- Capture bus when ds_to_es_valid && es_allowin. es_valid loads ds_to_es_valid when es_allowin.
- fire = es_valid && es_ready_go && ms_allowin.
- es_result selection:
  - HI for mfhi, LO for mflo.
  - Otherwise the ALU result.
- mult/multu: 64-bit product from 33-bit sign/zero-extended operands, combinational. Write HI=prod[63:32], LO=prod[31:0] on fire.
- mthi/mtlo: write src1 to HI/LO on fire.
- Divider states and transitions:
  - IDLE → BUSY when es_valid && (div||divu). Latch |src1|, |src2| and the sign flags; count=0.
  - BUSY: one restoring step per cycle. Leave for DONE when count==31.
  - DONE → IDLE on fire.
- Signed fix-up: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
- On fire in DONE: HI=remainder, LO=quotient.
- Divisor zero: same latency; HI/LO are not written.
- es_ready_go = !(div||divu) || state==DONE.
- Memory request:
  - data_sram_en = es_valid && (any load || any store) && ms_allowin.
  - data_sram_wen = 0 unless store && es_valid && ms_allowin.
- Store byte enables and data, a = addr[1:0]:
  - sb: wen = 0001<<a; wdata = {4{rt[7:0]}}.
  - sh: wen = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
  - sw: wen = 1111; wdata = rt.
  - swl: wen = 0001/0011/0111/1111 for a=0..3; wdata = rt >> (8*(3-a)).
  - swr: wen = 1111/1110/1100/1000 for a=0..3; wdata = rt << (8*a).
- Reset (asynchronous, including mid-divide):
  - es_valid=0, divider IDLE, count=0, HI=LO=0.
  - Outputs: es_allowin=1, es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0.

## Timing
- Non-divide instructions: one cycle in EX. The result is combinational from the pipeline register.
- Divide, entering EX in cycle N:
  - BUSY through cycles N+1..N+32.
  - DONE and es_ready_go=1 in cycle N+33.
  - Minimum occupancy is 34 cycles.
- DONE holds indefinitely while ms_allowin=0; HI/LO stay unchanged until fire.
- An mfhi/mflo entering the cycle after a HI/LO-writing fire reads the new value; no hazard logic is needed.
- es_allowin stays low during BUSY; the bus register is not overwritten.

## Structure
- mycpu.h holds: bus-width macros, bus field offsets, alu_op encoding, divider state encoding (IDLE=0, BUSY=1, DONE=2).
- Sub-module `div_iter` (radix-2 restoring):
  - inputs: start, signed, a, b
  - outputs: busy, done, quotient, remainder, plus an ack input that returns it to IDLE
- The existing `alu` module is instantiated as-is.

## Test plan
- divu 100/7 issued cycle 0 → es_ready_go first high cycle 33; LO=14, HI=2; a following mflo forwards 14.
- div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 5/0 → 34 cycles, HI/LO unchanged.
- mult 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands → HI=1, LO=0xFFFFFFFE.
- Byte-lane stores:
  - sb addr 0x1002, rt=0x12345678 → wen=0100, wdata=0x78787878.
  - swl addr 1, rt=0xAABBCCDD → wen=0011, wdata=0x0000AABB.
  - swr addr 2, same rt → wen=1100, wdata=0xCCDD0000.
- Divide reaches DONE with ms_allowin low for 5 cycles → es_to_ms_valid held, HI/LO unchanged, data_sram_en=0; HI/LO written at the fire edge.
- reset asserted at BUSY count 10 → immediately es_valid=0, es_allowin=1, state IDLE, HI=LO=0; the next divu after release takes a full 34 cycles.
